hazard_stall: RTL and testbench
===============================

Name: hazard_stall

Overview:
- Pipeline hold/kill controller for the 5-stage RV32I core. It is the counterpart to the forwarding unit: forwarding pushes M/W results back into E, while this block stops the front of the pipe and kills younger stages when forwarding cannot resolve a hazard.
- Handles three events:
  - load-use in D/E
  - taken branch/jump redirect from E
  - multi-cycle data-memory wait at M, with a timeout watchdog
- Exports saturating stall-cycle counters.

Parameters:
- CNT_W, 16, width of each stall performance counter.
- MEM_TIMEOUT, 64, maximum consecutive memory-wait stall cycles before forced release (must be 2 or more).
- TO_W, 7, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- Rs1D  in  5  rs1 of instruction in D
- Rs2D  in  5  rs2 of instruction in D
- RdE  in  5  rd of instruction in E
- opcodeE  in  7  opcode of instruction in E (7'd3 = load)
- RegWriteE  in  3  write-enable/type of E; nonzero means writes rd
- PCSrcE  in  1  taken branch/jump resolved in E
- MemReqM  in  1  M-stage data-memory access active
- MemReadyM  in  1  data memory completes the access this cycle
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- StallE  out  1  hold ID/EX register
- StallM  out  1  hold EX/MEM register
- FlushD  out  1  clear IF/ID to bubble
- FlushE  out  1  clear ID/EX to bubble
- FlushW  out  1  clear MEM/WB to bubble
- MemErr  out  1  sticky: memory timeout occurred
- LoadStallCnt  out  CNT_W  load-use stall cycles
- MemStallCnt  out  CNT_W  memory-wait stall cycles

Behaviour:
- Reset: state=RUN, wait counter=0, MemErr=0, both counters=0.
  - While rst is high, all Stall* and Flush* are forced to 0.
  - Reset mid-wait abandons the wait immediately.
- Stall/flush outputs are combinational from current state and inputs: zero-latency, effective in the same cycle.
- lu (load-use) = (opcodeE==7'd3) && (RegWriteE!=0) && (RdE!=0) && (RdE==Rs1D || RdE==Rs2D).
- memwait = MemReqM && !MemReadyM && (state!=RELEASE).
- Priority, evaluated each cycle:
  1. memwait: StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0. lu and PCSrcE are ignored; E is frozen, so both re-evaluate after release.
  2. else PCSrcE: FlushD=FlushE=1, no stalls. A simultaneous lu is discarded because the D instruction is wrong-path.
  3. else lu: StallF=StallD=1, FlushE=1.
  4. else all 0.
- FSM:
  - RUN: if memwait, go to MEM_WAIT with waitcnt=1; else stay.
  - MEM_WAIT:
    - if MemReadyM: go to RUN. No mem stall this cycle; the lower priorities apply.
    - else if waitcnt==MEM_TIMEOUT-1: go to RELEASE, set MemErr. This cycle still stalls, so the total stalled cycles equal MEM_TIMEOUT.
    - else waitcnt++.
  - RELEASE: memwait is masked, so the pipe advances one cycle and abandons the access; the lower priorities apply; next state is RUN.
- Ready asserted in the same cycle as the request in RUN: no stall, no state change.
- Counters: LoadStallCnt increments in cycles where rule 3 fires; MemStallCnt increments in cycles where rule 1 fires. Both saturate at all-ones and do not wrap.
- MemErr clears only on rst.

Decomposition:
- Shared package core_pkg holds:
  - OP_LOAD=7'd3
  - the state enum {RUN, MEM_WAIT, RELEASE}
  - the stall/flush struct if the top bundles them
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output q) is instantiated twice for the counters.

Test Plan:
- Load-use: opcodeE=3, RegWriteE=1, RdE=5, Rs1D=5 for 1 cycle -> StallF=StallD=FlushE=1 that cycle, LoadStallCnt 0→1. Repeat with RdE=0 -> no stall.
- Branch beats load-use: lu true and PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0, LoadStallCnt unchanged.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF/D/E/M and FlushW high exactly 3 cycles, MemStallCnt=3, state returns to RUN, MemErr=0. Same-cycle ready -> 0 stall cycles.
- Timeout (MEM_TIMEOUT=4): MemReqM=1, MemReadyM held 0 -> 4 stall cycles, then 1 release cycle with stalls=0 and MemErr=1 (sticky), then re-stall if still requesting.
- Async reset mid-wait: assert rst asynchronously in cycle 2 of a wait -> outputs 0 immediately, counters 0, MemErr 0, state RUN after release.
- Saturation (CNT_W=4): 20 load-use cycles -> LoadStallCnt holds 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the hazard hold/kill controller.
package core_pkg;

    localparam logic [6:0] OP_LOAD = 7'd3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        RELEASE  = 2'd2
    } state_e;

    // One bit per pipeline hold/kill control.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctl_t;

endpackage

// File: rtl/hazard_stall_if.sv
// Pipeline-side bundle: hazard sources in, hold/kill controls and counters out.
interface hazard_stall_if #(
    parameter int CNT_W = 16
) ();
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       RdE;
    logic [6:0]       opcodeE;
    logic [2:0]       RegWriteE;
    logic             PCSrcE;
    logic             MemReqM;
    logic             MemReadyM;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             MemErr;
    logic [CNT_W-1:0] LoadStallCnt;
    logic [CNT_W-1:0] MemStallCnt;

    // Pipeline datapath drives hazard sources and consumes the controls.
    modport master (
        output Rs1D, Rs2D, RdE, opcodeE, RegWriteE, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  MemErr, LoadStallCnt, MemStallCnt
    );

    // Hazard controller side.
    modport slave (
        input  Rs1D, Rs2D, RdE, opcodeE, RegWriteE, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output MemErr, LoadStallCnt, MemStallCnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count qualifying cycles, holding at full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (inc && !(&q))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/hazard_stall.sv
// Pipeline hold/kill controller: load-use, E-stage redirect, M-stage memory
// wait with timeout watchdog, plus saturating stall-cycle counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | no memory wait in progress
// MEM_WAIT | M-stage access pending, pipe frozen, wait counter running
// RELEASE  | watchdog expired: mask the wait for one cycle so M advances
module hazard_stall
    import core_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input logic           clk,
    input logic           rst,
    hazard_stall_if.slave bus
);

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e          state;
    logic [TO_W-1:0] waitcnt;
    logic            mem_err;
    logic            lu;
    logic            memwait;
    logic            ld_inc;
    logic            mem_inc;
    hz_ctl_t         ctl;
    logic [CNT_W-1:0] ld_q;
    logic [CNT_W-1:0] mem_q;

    assign lu = (bus.opcodeE == OP_LOAD) && (bus.RegWriteE != 3'd0) &&
                (bus.RdE != 5'd0) &&
                ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    // RELEASE masks the pending access so the pipe can move past it.
    assign memwait = bus.MemReqM && !bus.MemReadyM && (state != RELEASE);

    // Zero-latency priority: memory wait, then redirect, then load-use.
    always_comb begin
        ctl     = '0;
        ld_inc  = 1'b0;
        mem_inc = 1'b0;
        if (!rst) begin
            if (memwait) begin
                ctl.stall_f = 1'b1;
                ctl.stall_d = 1'b1;
                ctl.stall_e = 1'b1;
                ctl.stall_m = 1'b1;
                ctl.flush_w = 1'b1;
                mem_inc     = 1'b1;
            end else if (bus.PCSrcE) begin
                // Any load-use in D is on the wrong path and is dropped.
                ctl.flush_d = 1'b1;
                ctl.flush_e = 1'b1;
            end else if (lu) begin
                ctl.stall_f = 1'b1;
                ctl.stall_d = 1'b1;
                ctl.flush_e = 1'b1;
                ld_inc      = 1'b1;
            end
        end
    end

    // Memory-wait tracking and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            waitcnt <= '0;
            mem_err <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (memwait) begin
                        state   <= MEM_WAIT;
                        waitcnt <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!memwait) begin
                        state   <= RUN;
                        waitcnt <= '0;
                    end else if (waitcnt == WAIT_LAST) begin
                        state   <= RELEASE;
                        waitcnt <= '0;
                        mem_err <= 1'b1;
                    end else begin
                        waitcnt <= waitcnt + 1'b1;
                    end
                end
                RELEASE: begin
                    state   <= RUN;
                    waitcnt <= '0;
                end
                default: begin
                    state   <= RUN;
                    waitcnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_load_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ld_inc),
        .q   (ld_q)
    );

    sat_counter #(.W(CNT_W)) u_mem_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mem_inc),
        .q   (mem_q)
    );

    assign bus.StallF       = ctl.stall_f;
    assign bus.StallD       = ctl.stall_d;
    assign bus.StallE       = ctl.stall_e;
    assign bus.StallM       = ctl.stall_m;
    assign bus.FlushD       = ctl.flush_d;
    assign bus.FlushE       = ctl.flush_e;
    assign bus.FlushW       = ctl.flush_w;
    assign bus.MemErr       = mem_err;
    assign bus.LoadStallCnt = ld_q;
    assign bus.MemStallCnt  = mem_q;

endmodule

// File: tb/tb_hazard_stall.sv
// Directed bench for hazard_stall with a queue-based scoreboard.
module tb_hazard_stall;

    localparam int CW = 4;
    localparam int TO = 4;
    localparam logic [6:0] OPL = 7'd3;
    localparam logic [6:0] OPR = 7'h33;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] BR   = 7'b0000110;
    localparam logic [6:0] MW   = 7'b1111001;

    typedef struct {
        logic [6:0]    vec;
        logic          err;
        logic [CW-1:0] ld;
        logic [CW-1:0] mem;
        int            id;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_id   = 0;

    logic [CW-1:0] t_ld;
    logic [CW-1:0] t_mem;
    logic          t_err;
    int            t_run;

    hazard_stall_if #(.CNT_W(CW)) bus ();

    hazard_stall #(.CNT_W(CW), .MEM_TIMEOUT(TO), .TO_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic clear_tally();
        t_ld  = '0;
        t_mem = '0;
        t_err = 1'b0;
        t_run = 0;
    endtask

    // One pipeline cycle: drive at posedge+1, queue expectation, advance.
    task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [6:0] op,
                       input logic [2:0] rw, input logic pc,
                       input logic req, input logic rdy,
                       input logic [6:0] exp_vec, input bit mid_rst);
        exp_t e;
        bus.Rs1D      = rs1;
        bus.Rs2D      = rs2;
        bus.RdE       = rd;
        bus.opcodeE   = op;
        bus.RegWriteE = rw;
        bus.PCSrcE    = pc;
        bus.MemReqM   = req;
        bus.MemReadyM = rdy;
        if (mid_rst) begin
            #2 rst = 1'b1;
            clear_tally();
        end
        e.vec = exp_vec;
        e.err = t_err;
        e.ld  = t_ld;
        e.mem = t_mem;
        e.id  = cyc_id;
        q.push_back(e);
        cyc_id++;
        if (exp_vec == LU && !(&t_ld))  t_ld  = t_ld + 1'b1;
        if (exp_vec == MW && !(&t_mem)) t_mem = t_mem + 1'b1;
        if (exp_vec == MW) t_run++;
        else               t_run = 0;
        if (t_run == TO) t_err = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] got;
            e   = q.pop_front();
            got = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                   bus.FlushD, bus.FlushE, bus.FlushW};
            checks++;
            if (got !== e.vec) begin
                failures++;
                $display("FAIL ctl[cyc %0d]: got %b want %b", e.id, got, e.vec);
            end
            checks++;
            if (bus.MemErr !== e.err) begin
                failures++;
                $display("FAIL memerr[cyc %0d]: got %b want %b", e.id, bus.MemErr, e.err);
            end
            checks++;
            if (bus.LoadStallCnt !== e.ld) begin
                failures++;
                $display("FAIL ldcnt[cyc %0d]: got %0d want %0d", e.id, bus.LoadStallCnt, e.ld);
            end
            checks++;
            if (bus.MemStallCnt !== e.mem) begin
                failures++;
                $display("FAIL memcnt[cyc %0d]: got %0d want %0d", e.id, bus.MemStallCnt, e.mem);
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear_tally();
        @(posedge clk);
        #1;
        // Reset holds every control low even with hazards present.
        cyc(5'd5, 5'd0, 5'd5, OPL, 3'd1, 1'b1, 1'b1, 1'b0, NONE, 0);
        rst = 1'b0;

        // Load-use variants.
        cyc(5'd5, 5'd0, 5'd5, OPL, 3'd1, 1'b0, 1'b0, 1'b0, LU,   0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b0, 1'b0, NONE, 0);
        cyc(5'd0, 5'd0, 5'd0, OPL, 3'd1, 1'b0, 1'b0, 1'b0, NONE, 0);
        cyc(5'd1, 5'd7, 5'd7, OPL, 3'd2, 1'b0, 1'b0, 1'b0, LU,   0);
        cyc(5'd5, 5'd0, 5'd5, OPR, 3'd1, 1'b0, 1'b0, 1'b0, NONE, 0);
        cyc(5'd5, 5'd0, 5'd5, OPL, 3'd0, 1'b0, 1'b0, 1'b0, NONE, 0);
        cyc(5'd5, 5'd6, 5'd9, OPL, 3'd1, 1'b0, 1'b0, 1'b0, NONE, 0);

        // Redirect beats load-use.
        cyc(5'd5, 5'd0, 5'd5, OPL, 3'd1, 1'b1, 1'b0, 1'b0, BR,   0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b1, 1'b0, 1'b0, BR,   0);

        // Three-cycle memory wait; hazards underneath are frozen out.
        cyc(5'd5, 5'd0, 5'd5, OPL, 3'd1, 1'b0, 1'b1, 1'b0, MW,   0);
        cyc(5'd5, 5'd0, 5'd5, OPL, 3'd1, 1'b1, 1'b1, 1'b0, MW,   0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b1, 1'b0, MW,   0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b1, 1'b1, NONE, 0);
        // Same-cycle ready, then ready cycle with a redirect.
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b1, 1'b1, NONE, 0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b1, 1'b1, 1'b1, BR,   0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b0, 1'b0, NONE, 0);

        // Timeout: four stalled cycles, one release cycle, then re-stall.
        for (int i = 0; i < TO; i++)
            cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b1, 1'b0, MW, 0);
        cyc(5'd5, 5'd0, 5'd5, OPL, 3'd1, 1'b0, 1'b1, 1'b0, LU,   0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b1, 1'b0, MW,   0);

        // Asynchronous reset in the second wait cycle.
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b1, 1'b0, NONE, 1);
        rst = 1'b0;
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b0, 1'b0, NONE, 0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b1, 1'b0, MW,   0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b1, 1'b1, NONE, 0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b1, 1'b0, MW,   0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b0, 1'b0, NONE, 0);

        // Load-use counter saturation.
        for (int i = 0; i < 20; i++)
            cyc(5'd3, 5'd3, 5'd3, OPL, 3'd1, 1'b0, 1'b0, 1'b0, LU, 0);
        cyc(5'd0, 5'd0, 5'd0, OPR, 3'd0, 1'b0, 1'b0, 1'b0, NONE, 0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
